// File: rtl/tcm_banked_ram_pkg.sv
// Shared constants for the banked tightly-coupled memory: default geometry and port indices.
package tcm_banked_ram_pkg;

  localparam int TCM_BANKED_RAM_DW    = 32;
  localparam int TCM_BANKED_RAM_AW    = 14;
  localparam int TCM_BANKED_RAM_NBANK = 2;

  localparam int P_IFU = 0;
  localparam int P_LSU = 1;
  localparam int NPORT = 2;

  // Bank-index width; a single bank needs no index bits.
  function automatic int bank_bits(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 0;
  endfunction

endpackage

// File: rtl/sim_ram.sv
// Behavioural single-port synchronous RAM with byte write mask and registered read data.
// FORCE_X2ZERO returns unknown read bits as 0 in simulation.
module sim_ram #(
  parameter int DP           = 1024,
  parameter int DW           = 32,
  parameter int MW           = 4,
  parameter int AW           = 10,
  parameter int FORCE_X2ZERO = 1
) (
  input  logic          clk,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          we,
  input  logic [MW-1:0] wem,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] dout_r;

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        for (int i = 0; i < MW; i++) begin
          if (wem[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
        end
      end else begin
        dout_r <= mem[addr];
      end
    end
  end

  generate
    if (FORCE_X2ZERO != 0) begin : g_x2zero
      for (genvar i = 0; i < DW; i++) begin : g_bit
        assign dout[i] = (dout_r[i] === 1'b1);
      end
    end else begin : g_raw
      assign dout = dout_r;
    end
  endgenerate

endmodule

// File: rtl/tcm_ram_bank.sv
// One memory bank: per-bank arbitration between the fetch and load/store ports plus the request mux.
// Define TCM_BANKED_RAM_RR_ARB_EN for round-robin conflict resolution; default is fixed p1 priority.
module tcm_ram_bank
  import tcm_banked_ram_pkg::*;
#(
  parameter int DW           = 32,
  parameter int MW           = DW / 8,
  parameter int RW           = 13,
  parameter int FORCE_X2ZERO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] vld,
  input  logic [NPORT-1:0] ok,
  input  logic [NPORT-1:0] we,
  input  logic [RW-1:0]    row0,
  input  logic [RW-1:0]    row1,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  input  logic [MW-1:0]    wem0,
  input  logic [MW-1:0]    wem1,
  output logic [NPORT-1:0] gnt,
  output logic [DW-1:0]    dout
);

  logic             favour_p0;
  logic             conflict;
  logic             cs;
  logic             mem_we;
  logic [NPORT-1:0] acc;
  logic [RW-1:0]    mem_row;
  logic [DW-1:0]    mem_din;
  logic [MW-1:0]    mem_wem;

  assign conflict   = vld[P_IFU] & vld[P_LSU];
  assign gnt[P_LSU] = vld[P_LSU] & !(conflict & favour_p0);
  assign gnt[P_IFU] = vld[P_IFU] & !(conflict & !favour_p0);

  // A granted port whose response slot is stalled leaves the bank idle.
  assign acc = gnt & ok;
  assign cs  = (|acc) & !rst;

`ifdef TCM_BANKED_RAM_RR_ARB_EN
  logic ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (conflict & cs) begin
      ptr_q <= ~ptr_q;
    end
  end

  assign favour_p0 = ptr_q;
`else
  assign favour_p0 = 1'b0;
`endif

  assign mem_we  = acc[P_LSU] ? we[P_LSU] : we[P_IFU];
  assign mem_row = acc[P_LSU] ? row1      : row0;
  assign mem_din = acc[P_LSU] ? wdata1    : wdata0;
  assign mem_wem = acc[P_LSU] ? wem1      : wem0;

  sim_ram #(
    .DP          (2 ** RW),
    .DW          (DW),
    .MW          (MW),
    .AW          (RW),
    .FORCE_X2ZERO(FORCE_X2ZERO)
  ) u_ram (
    .clk (clk),
    .din (mem_din),
    .addr(mem_row),
    .cs  (cs),
    .we  (mem_we),
    .wem (mem_wem),
    .dout(dout)
  );

endmodule

// File: rtl/tcm_banked_ram.sv
// Dual-port word-interleaved banked TCM: port 0 fetch, port 1 load/store, with response hold on stall.
// Optional round-robin bank arbitration via TCM_BANKED_RAM_RR_ARB_EN.
module tcm_banked_ram
  import tcm_banked_ram_pkg::*;
#(
  parameter int DW           = TCM_BANKED_RAM_DW,
  parameter int MW           = DW / 8,
  parameter int AW           = TCM_BANKED_RAM_AW,
  parameter int NBANK        = TCM_BANKED_RAM_NBANK,
  parameter int FORCE_X2ZERO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_we,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  input  logic [MW-1:0] p0_req_wem,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_we,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  input  logic [MW-1:0] p1_req_wem,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [DW-1:0] p1_rsp_rdata
);

  localparam int BW = bank_bits(NBANK);
  localparam int BI = (BW > 0) ? BW : 1;
  localparam int RW = AW - BW;

  logic [NPORT-1:0] req_valid, req_we, req_ready, rsp_ready, port_ok, accept;
  logic [NPORT-1:0] rsp_valid_q, is_write_q, fresh_q;
  logic [AW-1:0]    req_addr   [NPORT];
  logic [DW-1:0]    req_wdata  [NPORT];
  logic [MW-1:0]    req_wem    [NPORT];
  logic [BI-1:0]    req_bank   [NPORT];
  logic [RW-1:0]    req_row    [NPORT];
  logic [BI-1:0]    bank_sel_q [NPORT];
  logic [DW-1:0]    hold_q     [NPORT];
  logic [DW-1:0]    rsp_data   [NPORT];
  logic [DW-1:0]    rsp_rdata  [NPORT];
  logic [DW-1:0]    bank_dout  [NBANK];
  logic [NPORT-1:0] bank_gnt   [NBANK];

  assign req_valid           = {p1_req_valid, p0_req_valid};
  assign req_we              = {p1_req_we, p0_req_we};
  assign rsp_ready           = {p1_rsp_ready, p0_rsp_ready};
  assign req_addr[P_IFU]     = p0_req_addr;
  assign req_addr[P_LSU]     = p1_req_addr;
  assign req_wdata[P_IFU]    = p0_req_wdata;
  assign req_wdata[P_LSU]    = p1_req_wdata;
  assign req_wem[P_IFU]      = p0_req_wem;
  assign req_wem[P_LSU]      = p1_req_wem;

  // Low address bits pick the bank so sequential words spread across banks.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      req_bank[p]  = BI'(req_addr[p] & AW'(NBANK - 1));
      req_row[p]   = RW'(req_addr[p] >> BW);
      port_ok[p]   = (!rsp_valid_q[p] | rsp_ready[p]) & !rst;
      req_ready[p] = bank_gnt[req_bank[p]][p] & port_ok[p];
      accept[p]    = req_valid[p] & req_ready[p];
      rsp_data[p]  = is_write_q[p] ? '0 : bank_dout[bank_sel_q[p]];
      rsp_rdata[p] = !rsp_valid_q[p] ? '0 : (fresh_q[p] ? rsp_data[p] : hold_q[p]);
    end
  end

  generate
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic [NPORT-1:0] hit;

      assign hit = {req_valid[P_LSU] & (req_bank[P_LSU] == BI'(b)),
                    req_valid[P_IFU] & (req_bank[P_IFU] == BI'(b))};

      tcm_ram_bank #(
        .DW          (DW),
        .MW          (MW),
        .RW          (RW),
        .FORCE_X2ZERO(FORCE_X2ZERO)
      ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .vld   (hit),
        .ok    (port_ok),
        .we    (req_we),
        .row0  (req_row[P_IFU]),
        .row1  (req_row[P_LSU]),
        .wdata0(req_wdata[P_IFU]),
        .wdata1(req_wdata[P_LSU]),
        .wem0  (req_wem[P_IFU]),
        .wem1  (req_wem[P_LSU]),
        .gnt   (bank_gnt[b]),
        .dout  (bank_dout[b])
      );
    end
  endgenerate

  // Response stage: bank output is live only in the fresh cycle, then captured into hold_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NPORT; p++) begin
        rsp_valid_q[p] <= 1'b0;
        is_write_q[p]  <= 1'b0;
        fresh_q[p]     <= 1'b0;
        bank_sel_q[p]  <= '0;
        hold_q[p]      <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        rsp_valid_q[p] <= accept[p] | (rsp_valid_q[p] & !rsp_ready[p]);
        if (accept[p]) begin
          is_write_q[p] <= req_we[p];
          bank_sel_q[p] <= req_bank[p];
          fresh_q[p]    <= 1'b1;
        end else if (fresh_q[p]) begin
          fresh_q[p] <= 1'b0;
          if (rsp_valid_q[p] & !rsp_ready[p]) hold_q[p] <= rsp_data[p];
        end
      end
    end
  end

  assign p0_req_ready = req_ready[P_IFU];
  assign p1_req_ready = req_ready[P_LSU];
  assign p0_rsp_valid = rsp_valid_q[P_IFU];
  assign p1_rsp_valid = rsp_valid_q[P_LSU];
  assign p0_rsp_rdata = rsp_rdata[P_IFU];
  assign p1_rsp_rdata = rsp_rdata[P_LSU];

endmodule

// File: tb/tb_tcm_banked_ram.sv
// Testbench for tcm_banked_ram (default build: NBANK=2, fixed p1 priority) with a behavioural memory model.
module tb_tcm_banked_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  v, we, rr;
  logic [13:0] ad [2];
  logic [31:0] wd [2];
  logic [3:0]  wm [2];

  logic        p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;

  int checks = 0;
  int errors = 0;

  // Model: word memory for the addresses used, and one response slot per port.
  logic [31:0] m_mem [64];
  bit   [1:0]  m_vld;
  logic [31:0] m_dat [2];
  bit   [1:0]  e_rdy;
  logic [1:0]  o_rdy, o_vld;
  logic [31:0] o_dat [2];

  always #5 clk = ~clk;

  tcm_banked_ram dut (
    .clk         (clk),
    .rst         (rst),
    .p0_req_valid(v[0]),
    .p0_req_ready(p0_req_ready),
    .p0_req_we   (we[0]),
    .p0_req_addr (ad[0]),
    .p0_req_wdata(wd[0]),
    .p0_req_wem  (wm[0]),
    .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(rr[0]),
    .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(v[1]),
    .p1_req_ready(p1_req_ready),
    .p1_req_we   (we[1]),
    .p1_req_addr (ad[1]),
    .p1_req_wdata(wd[1]),
    .p1_req_wem  (wm[1]),
    .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(rr[1]),
    .p1_rsp_rdata(p1_rsp_rdata)
  );

  task automatic set_req(input int p, input bit val, input bit w, input int a,
                         input logic [31:0] d, input logic [3:0] m);
    v[p]  = val;
    we[p] = w;
    ad[p] = 14'(a);
    wd[p] = d;
    wm[p] = m;
  endtask

  // Mid-cycle: capture outputs and derive expected readiness from the arbitration rules.
  task automatic observe();
    bit stall0, stall1;
    @(negedge clk);
    o_rdy    = {p1_req_ready, p0_req_ready};
    o_vld    = {p1_rsp_valid, p0_rsp_valid};
    o_dat[0] = p0_rsp_rdata;
    o_dat[1] = p1_rsp_rdata;
    stall0   = m_vld[0] && !rr[0];
    stall1   = m_vld[1] && !rr[1];
    e_rdy[1] = v[1] && !stall1;
    e_rdy[0] = v[0] && !(v[1] && ((ad[0] % 2) == (ad[1] % 2))) && !stall0;
  endtask

  task automatic commit();
    bit   [1:0]  nv;
    logic [31:0] nd [2];
    for (int p = 0; p < 2; p++) begin
      nd[p] = m_dat[p];
      if (v[p] && e_rdy[p]) begin
        nv[p] = 1'b1;
        nd[p] = we[p] ? 32'h0 : m_mem[ad[p][5:0]];
      end else begin
        nv[p] = m_vld[p] && !rr[p];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (v[p] && e_rdy[p] && we[p]) begin
        for (int i = 0; i < 4; i++)
          if (wm[p][i]) m_mem[ad[p][5:0]][8*i +: 8] = wd[p][8*i +: 8];
      end
    end
    m_vld    = nv;
    m_dat[0] = nd[0];
    m_dat[1] = nd[1];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v = '0; we = '0; rr = 2'b11;
    for (int p = 0; p < 2; p++) set_req(p, 0, 0, 0, 32'h0, 4'h0);
    m_vld = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_p0_valid: got %b exp 0", p0_rsp_valid); end
    checks++; if (p1_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_p1_valid: got %b exp 0", p1_rsp_valid); end
    checks++; if (p0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_p0_rdata: got %h exp 0", p0_rsp_rdata); end
    checks++; if (p1_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_p1_rdata: got %h exp 0", p1_rsp_rdata); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_preload();
    for (int a = 0; a < 64; a++) begin
      set_req(1, 1, 1, a, $urandom, 4'hF);
      observe();
      checks++; if (o_rdy[1] !== 1'b1) begin errors++; $display("FAIL preload_ready a=%0d: got %b exp 1", a, o_rdy[1]); end
      commit();
    end
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    observe();
    commit();
  endtask

  task automatic test_write_read();
    set_req(1, 1, 1, 'h10, 32'hDEADBEEF, 4'hF);
    observe();
    checks++; if (o_rdy[1] !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b exp 1", o_rdy[1]); end
    commit();
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    set_req(0, 1, 0, 'h10, 32'h0, 4'h0);
    observe();
    checks++; if (o_vld[1] !== 1'b1 || o_dat[1] !== 32'h0) begin errors++; $display("FAIL wr_rsp: got v=%b d=%h exp v=1 d=0", o_vld[1], o_dat[1]); end
    checks++; if (o_rdy[0] !== 1'b1 || o_vld[0] !== 1'b0) begin errors++; $display("FAIL rd_accept: got rdy=%b v=%b exp rdy=1 v=0", o_rdy[0], o_vld[0]); end
    commit();
    set_req(0, 0, 0, 0, 32'h0, 4'h0);
    observe();
    checks++; if (o_vld[0] !== 1'b1 || o_dat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got v=%b d=%h exp v=1 d=deadbeef", o_vld[0], o_dat[0]); end
    commit();
  endtask

  task automatic test_byte_mask();
    set_req(1, 1, 1, 'h21, 32'h11223344, 4'hF);
    observe(); commit();
    set_req(1, 1, 1, 'h21, 32'hAABBCCDD, 4'b0101);
    observe();
    checks++; if (o_vld[1] !== 1'b1 || o_dat[1] !== 32'h0) begin errors++; $display("FAIL mask_wr_rsp: got v=%b d=%h exp v=1 d=0", o_vld[1], o_dat[1]); end
    commit();
    set_req(1, 1, 0, 'h21, 32'h0, 4'h0);
    observe(); commit();
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    observe();
    checks++; if (o_vld[1] !== 1'b1 || o_dat[1] !== 32'h11BB33DD) begin errors++; $display("FAIL mask_rd: got v=%b d=%h exp v=1 d=11bb33dd", o_vld[1], o_dat[1]); end
    commit();
  endtask

  task automatic test_parallel();
    logic [31:0] x0, x1;
    x0 = m_mem['h4];
    x1 = m_mem['h5];
    set_req(0, 1, 0, 'h4, 32'h0, 4'h0);
    set_req(1, 1, 0, 'h5, 32'h0, 4'h0);
    observe();
    checks++; if (o_rdy !== 2'b11) begin errors++; $display("FAIL par_ready: got %b exp 11", o_rdy); end
    commit();
    set_req(0, 0, 0, 0, 32'h0, 4'h0);
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    observe();
    checks++; if (o_vld !== 2'b11 || o_dat[0] !== x0 || o_dat[1] !== x1) begin errors++; $display("FAIL par_data: got v=%b %h %h exp v=11 %h %h", o_vld, o_dat[0], o_dat[1], x0, x1); end
    commit();
  endtask

  task automatic test_conflict();
    set_req(0, 1, 0, 'h8, 32'h0, 4'h0);
    set_req(1, 1, 0, 'hA, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      observe();
      checks++; if (o_rdy !== 2'b10) begin errors++; $display("FAIL conflict_grant c=%0d: got %b exp 10", k, o_rdy); end
      if (k > 0) begin
        checks++; if (o_vld[1] !== 1'b1 || o_dat[1] !== m_mem['hA]) begin errors++; $display("FAIL conflict_data c=%0d: got %h exp %h", k, o_dat[1], m_mem['hA]); end
      end
      commit();
    end
    set_req(0, 0, 0, 0, 32'h0, 4'h0);
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    observe(); commit();
  endtask

  task automatic test_stall_hold();
    set_req(1, 1, 1, 'h8, 32'hCAFE0001, 4'hF);
    observe(); commit();
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    set_req(0, 1, 0, 'h8, 32'h0, 4'h0);
    observe(); commit();
    rr[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1, 0, 'hA, 32'h0, 4'h0);
      set_req(1, 1, (k % 2 == 0), 'h8, $urandom, 4'hF);
      observe();
      checks++; if (o_vld[0] !== 1'b1 || o_dat[0] !== 32'hCAFE0001) begin errors++; $display("FAIL stall_hold c=%0d: got v=%b d=%h exp v=1 d=cafe0001", k, o_vld[0], o_dat[0]); end
      checks++; if (o_rdy[0] !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d: got %b exp 0", k, o_rdy[0]); end
      commit();
    end
    rr[0] = 1'b1;
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    observe();
    checks++; if (o_dat[0] !== 32'hCAFE0001 || o_rdy[0] !== 1'b1) begin errors++; $display("FAIL stall_release: got d=%h rdy=%b exp d=cafe0001 rdy=1", o_dat[0], o_rdy[0]); end
    commit();
    set_req(0, 0, 0, 0, 32'h0, 4'h0);
    observe();
    checks++; if (o_vld[0] !== 1'b1 || o_dat[0] !== m_dat[0]) begin errors++; $display("FAIL stall_next: got v=%b d=%h exp v=1 d=%h", o_vld[0], o_dat[0], m_dat[0]); end
    commit();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++)
        set_req(p, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63), $urandom, 4'($urandom));
      rr = 2'($urandom);
      observe();
      for (int p = 0; p < 2; p++) begin
        checks++; if (o_rdy[p] !== e_rdy[p]) begin errors++; $display("FAIL rand_ready c=%0d p=%0d: got %b exp %b", c, p, o_rdy[p], e_rdy[p]); end
        checks++; if (o_vld[p] !== m_vld[p]) begin errors++; $display("FAIL rand_valid c=%0d p=%0d: got %b exp %b", c, p, o_vld[p], m_vld[p]); end
        if (m_vld[p]) begin
          checks++; if (o_dat[p] !== m_dat[p]) begin errors++; $display("FAIL rand_data c=%0d p=%0d: got %h exp %h", c, p, o_dat[p], m_dat[p]); end
        end
      end
      commit();
    end
    set_req(0, 0, 0, 0, 32'h0, 4'h0);
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    rr = 2'b11;
    observe(); commit();
  endtask

  task automatic test_reset_mid();
    set_req(1, 1, 1, 'h30, 32'h5A5A0030, 4'hF);
    observe(); commit();
    set_req(1, 0, 0, 0, 32'h0, 4'h0);
    set_req(0, 1, 0, 'h30, 32'h0, 4'h0);
    observe(); commit();
    set_req(0, 0, 0, 0, 32'h0, 4'h0);
    #1;
    checks++; if (p0_rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b exp 1", p0_rsp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (p0_rsp_valid !== 1'b0 || p0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_async: got v=%b d=%h exp v=0 d=0", p0_rsp_valid, p0_rsp_rdata); end
    m_vld = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    observe();
    checks++; if (o_vld !== 2'b00) begin errors++; $display("FAIL rstmid_stale: got %b exp 00", o_vld); end
    commit();
    set_req(0, 1, 0, 'h30, 32'h0, 4'h0);
    observe(); commit();
    set_req(0, 0, 0, 0, 32'h0, 4'h0);
    observe();
    checks++; if (o_vld[0] !== 1'b1 || o_dat[0] !== 32'h5A5A0030) begin errors++; $display("FAIL rstmid_mem: got v=%b d=%h exp v=1 d=5a5a0030", o_vld[0], o_dat[0]); end
    commit();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_write_read();
    test_byte_mask();
    test_parallel();
    test_conflict();
    test_stall_hold();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
